// File: rtl/fmc_adc_trigout_pkg.sv
// Shared types and constants for the trigger-out timestamp FIFO.
package fmc_adc_trigout_pkg;

    localparam int unsigned c_NUM_SRC = 5;

    localparam int unsigned c_SRC_CH1 = 0;
    localparam int unsigned c_SRC_CH2 = 1;
    localparam int unsigned c_SRC_CH3 = 2;
    localparam int unsigned c_SRC_CH4 = 3;
    localparam int unsigned c_SRC_EXT = 4;

    // One queued trigger event: which sources fired plus the WR time at capture.
    typedef struct packed {
        logic [4:0]  mask;
        logic [39:0] sec;
        logic [27:0] cycles;
        logic        valid;
    } t_trigout_entry;

    localparam int unsigned c_ENTRY_W = $bits(t_trigout_entry);

endpackage

// File: rtl/fmc_adc_ts_fifo.sv
// Generic synchronous show-ahead FIFO with flush. The head output keeps the
// last popped word while the FIFO is empty.
module fmc_adc_ts_fifo #(
    parameter int unsigned g_WIDTH = 8,
    parameter int unsigned g_DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [g_WIDTH-1:0]       din,
    input  logic                     pop,
    input  logic                     clr,
    output logic [g_WIDTH-1:0]       dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(g_DEPTH):0] count
);

    localparam int unsigned c_AW = $clog2(g_DEPTH);

    logic [g_WIDTH-1:0] mem [g_DEPTH];
    logic [g_WIDTH-1:0] last_q;
    logic [c_AW:0]      wr_q;
    logic [c_AW:0]      rd_q;
    logic               do_push;
    logic               do_pop;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[c_AW] != rd_q[c_AW]) &&
                   (wr_q[c_AW-1:0] == rd_q[c_AW-1:0]);
    assign count = wr_q - rd_q;

    // A pop frees a slot in the same cycle, so push into a full FIFO is fine then.
    assign do_pop  = pop & ~empty & ~clr;
    assign do_push = push & (~full | do_pop) & ~clr;

    assign dout = empty ? last_q : mem[rd_q[c_AW-1:0]];

    // Storage write; no reset needed since contents are only visible via pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q[c_AW-1:0]] <= din;
        end
    end

    // Pointer update with flush priority, and capture of the word being popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            last_q <= '0;
        end else if (clr) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q   <= rd_q + 1'b1;
                last_q <= mem[rd_q[c_AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/fmc_adc_trigout_ts_fifo.sv
// Trigger-out timestamp queue: rising-edge detect on CH1..CH4/EXT, optional
// per-source holdoff (macro FMC_ADC_TRIGOUT_HOLDOFF_EN), entry build and
// sticky overflow in front of a show-ahead FIFO.
module fmc_adc_trigout_ts_fifo
    import fmc_adc_trigout_pkg::*;
#(
    parameter int unsigned g_FIFO_DEPTH = 16,
    parameter int unsigned g_HOLDOFF    = 8
) (
    input  logic                          sys_clk_i,
    input  logic                          sys_rst_n_i,
    input  logic [3:0]                    trig_ch_i,
    input  logic                          trig_ext_i,
    input  logic [4:0]                    en_i,
    input  logic [39:0]                   tai_i,
    input  logic [27:0]                   cycles_i,
    input  logic                          time_valid_i,
    input  logic                          pop_i,
    input  logic                          clr_i,
    output logic                          ts_present_o,
    output logic [4:0]                    ts_mask_o,
    output logic [39:0]                   ts_sec_o,
    output logic [27:0]                   ts_cycles_o,
    output logic                          ts_valid_o,
    output logic [$clog2(g_FIFO_DEPTH):0] count_o,
    output logic                          overflow_o
);

    if (g_FIFO_DEPTH < 2 || (g_FIFO_DEPTH & (g_FIFO_DEPTH - 1)) != 0 || g_HOLDOFF < 1) begin : g_bad_cfg
        $error("fmc_adc_trigout_ts_fifo: depth must be a power of two >= 2, holdoff >= 1");
    end

    logic [c_NUM_SRC-1:0] src;
    logic [c_NUM_SRC-1:0] prev_q;
    logic [c_NUM_SRC-1:0] rise;
    logic [c_NUM_SRC-1:0] hit;
    logic                 push;
    logic                 full;
    logic                 empty;
    t_trigout_entry       new_entry;
    t_trigout_entry       head;

    assign src  = {trig_ext_i, trig_ch_i};
    assign rise = src & ~prev_q;

    // Edge history always follows the inputs, regardless of enables or flush.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            prev_q <= '0;
        end else begin
            prev_q <= src;
        end
    end

`ifdef FMC_ADC_TRIGOUT_HOLDOFF_EN
    localparam int unsigned c_HO_W = (g_HOLDOFF > 1) ? $clog2(g_HOLDOFF) : 1;
    // The accepting cycle counts as the first holdoff cycle, hence the -1.
    localparam logic [c_HO_W-1:0] c_HO_LOAD = c_HO_W'(g_HOLDOFF - 1);

    logic [c_HO_W-1:0]    ho_cnt_q [c_NUM_SRC];
    logic [c_NUM_SRC-1:0] armed;

    // A source is armed once its holdoff counter has run out.
    always_comb begin
        armed = '0;
        for (int unsigned i = 0; i < c_NUM_SRC; i++) begin
            armed[i] = (ho_cnt_q[i] == '0);
        end
    end

    assign hit = rise & en_i & armed;

    // Per-source holdoff down-counters, reloaded on each accepted edge.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            for (int unsigned i = 0; i < c_NUM_SRC; i++) begin
                ho_cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < c_NUM_SRC; i++) begin
                if (hit[i]) begin
                    ho_cnt_q[i] <= c_HO_LOAD;
                end else if (ho_cnt_q[i] != '0) begin
                    ho_cnt_q[i] <= ho_cnt_q[i] - 1'b1;
                end
            end
        end
    end
`else
    assign hit = rise & en_i;
`endif

    assign push             = |hit;
    assign new_entry.mask   = hit;
    assign new_entry.sec    = tai_i;
    assign new_entry.cycles = cycles_i;
    assign new_entry.valid  = time_valid_i;

    fmc_adc_ts_fifo #(
        .g_WIDTH (c_ENTRY_W),
        .g_DEPTH (g_FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk_i),
        .rst_n (sys_rst_n_i),
        .push  (push),
        .din   (new_entry),
        .pop   (pop_i),
        .clr   (clr_i),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count_o)
    );

    // Sticky drop flag: set on push into a full FIFO that is not popped this cycle.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            overflow_o <= 1'b0;
        end else if (clr_i) begin
            overflow_o <= 1'b0;
        end else if (push && full && !pop_i) begin
            overflow_o <= 1'b1;
        end
    end

    assign ts_present_o = ~empty;
    assign ts_mask_o    = head.mask;
    assign ts_sec_o     = head.sec;
    assign ts_cycles_o  = head.cycles;
    assign ts_valid_o   = head.valid;

endmodule
